comb_pwm_display: RTL and testbench



---
 rtl/comb_pwm_display.sv | 90 +++++++++
 tb/tb_comb_pwm_display.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/comb_pwm_display.sv
// comb_pwm_display: switch-driven 8-bit PWM plus one common-anode hex digit.
// The operand is captured once (ocho_q); the PWM duty reloads only at period
// boundaries while the digit and dot follow ocho_q every clock.
module comb_pwm_display #(
  parameter int PRESCALE = 1
) (
  input  logic       sys_clk_pin,
  input  logic       rst_n,
  input  logic [7:0] Ocho,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       h,
  output logic       pwm
);

  // Prescaler needs at least one bit even when PRESCALE is 1.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [7:0]    ocho_q;
  logic [PW-1:0] presc;
  logic [7:0]    cnt;
  logic [7:0]    duty;
  logic          tick;
  logic [6:0]    seg_nxt;

  // Active-low hex pattern, bit order {a,b,c,d,e,f,g}.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0: hex7 = 7'b0000001;
      4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;
      4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;
      4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;
      4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;
      4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  assign tick    = (presc == PMAX);
  assign seg_nxt = hex7(ocho_q[7:4]);

  // Single capture point for the asynchronous switches.
  always_ff @(posedge sys_clk_pin) begin
    if (!rst_n) ocho_q <= '0;
    else        ocho_q <= Ocho;
  end

  // Prescaler, PWM counter and period-boundary duty reload.
  always_ff @(posedge sys_clk_pin) begin
    if (!rst_n) begin
      presc <= '0;
      cnt   <= '0;
      duty  <= '0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) begin
        cnt <= cnt + 8'd1;
        if (cnt == 8'hFF) duty <= ocho_q;
      end
    end
  end

  // Registered compare; pwm lags cnt by one clock.
  always_ff @(posedge sys_clk_pin) begin
    if (!rst_n) pwm <= 1'b0;
    else        pwm <= (cnt < duty);
  end

  // Digit and dot track ocho_q directly, independent of the PWM period.
  always_ff @(posedge sys_clk_pin) begin
    if (!rst_n) {a, b, c, d, e, f, g, h} <= 8'hFF;
    else        {a, b, c, d, e, f, g, h} <= {seg_nxt, ~ocho_q[3]};
  end

endmodule

// File: tb/tb_comb_pwm_display.sv
// Randomized/directed bench for comb_pwm_display, checking PRESCALE=1 and 4
// instances against a period-level reference model.
module tb_comb_pwm_display;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] Ocho;
  logic a1, b1, c1, d1, e1, f1, g1, h1, pwm1;
  logic a4, b4, c4, d4, e4, f4, g4, h4, pwm4;

  always #20 clk = ~clk;

  comb_pwm_display #(.PRESCALE(1)) dut1 (
    .sys_clk_pin(clk), .rst_n(rst_n), .Ocho(Ocho),
    .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1), .h(h1), .pwm(pwm1)
  );

  comb_pwm_display #(.PRESCALE(4)) dut4 (
    .sys_clk_pin(clk), .rst_n(rst_n), .Ocho(Ocho),
    .a(a4), .b(b4), .c(c4), .d(d4), .e(e4), .f(f4), .g(g4), .h(h4), .pwm(pwm4)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Hex digit table, active-low {a..g}.
  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Reference model state: edges since reset release, captured operand,
  // and the duty in force for the current period of each instance.
  int         k = 0;
  logic [7:0] qreg = 8'h00;
  int         duty_m [2] = '{0, 0};
  int         pres   [2] = '{1, 4};
  logic [7:0] want_seg;
  logic       want_pwm [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, want, $time);
    end
  endtask

  // One clock: drive at negedge, let the rising edge happen, check at negedge.
  task automatic step(input logic r, input logic [7:0] o);
    int per, pos;
    rst_n = r;
    Ocho  = o;
    @(posedge clk);
    @(negedge clk);
    if (!r) begin
      k        = 0;
      qreg     = 8'h00;
      duty_m   = '{0, 0};
      want_seg = 8'hFF;
      want_pwm = '{1'b0, 1'b0};
    end else begin
      k++;
      want_seg = {seg_tab[qreg[7:4]], ~qreg[3]};
      for (int i = 0; i < 2; i++) begin
        per = 256 * pres[i];
        pos = (k - 1) % per;
        // High for the first duty*PRESCALE clocks of each period.
        want_pwm[i] = (pos < duty_m[i] * pres[i]);
        if (k % per == 0) duty_m[i] = int'(qreg);
      end
      qreg = o;
    end
    chk("seg_p1", {a1, b1, c1, d1, e1, f1, g1, h1}, want_seg);
    chk("seg_p4", {a4, b4, c4, d4, e4, f4, g4, h4}, want_seg);
    chk("pwm_p1", pwm1, want_pwm[0]);
    chk("pwm_p4", pwm4, want_pwm[1]);
  endtask

  task automatic run(input int n, input logic [7:0] o, output int hi1, output int hi4);
    hi1 = 0;
    hi4 = 0;
    for (int i = 0; i < n; i++) begin
      step(1'b1, o);
      hi1 += int'(pwm1);
      hi4 += int'(pwm4);
    end
  endtask

  initial begin
    int x1, x4, y1, y4;
    logic [7:0] ro;

    // Reset with 0x0F, then watch the first periods.
    for (int i = 0; i < 3; i++) step(1'b0, 8'h0F);
    chk("rst_pwm", pwm1, 1'b0);
    chk("rst_seg", {a1, b1, c1, d1, e1, f1, g1, h1}, 8'hFF);
    step(1'b1, 8'h0F);
    step(1'b1, 8'h0F);
    chk("rel2_seg", {a1, b1, c1, d1, e1, f1, g1, h1}, {7'b0000001, 1'b0});
    run(254, 8'h0F, x1, x4);
    chk("first_period_hi", x1, 0);
    run(256, 8'h0F, x1, x4);
    chk("p0f_hi_a", x1, 15);
    run(256, 8'h0F, x1, x4);
    chk("p0f_hi_b", x1, 15);

    // 0x00: one period finishing the old duty, then none.
    run(256, 8'h00, x1, x4);
    chk("p00_old", x1, 15);
    run(512, 8'h00, x1, x4);
    chk("p00_hi", x1, 0);
    chk("p00_seg", {a1, b1, c1, d1, e1, f1, g1, h1}, {7'b0000001, 1'b1});

    // 0xFF: 255 of every 256 clocks.
    run(256, 8'hFF, x1, x4);
    chk("pff_old", x1, 0);
    run(512, 8'hFF, x1, x4);
    chk("pff_hi", x1, 510);
    chk("pff_seg", {a1, b1, c1, d1, e1, f1, g1, h1}, {7'b0111000, 1'b0});

    // 0x40 -> 0xC0 mid-period.
    run(256, 8'h40, x1, x4);
    chk("p40_old", x1, 255);
    run(100, 8'h40, x1, x4);
    step(1'b1, 8'hC0);
    y1 = int'(pwm1);
    chk("chg_seg1", {a1, b1, c1, d1, e1, f1, g1, h1}, {7'b1001100, 1'b1});
    step(1'b1, 8'hC0);
    y1 += int'(pwm1);
    chk("chg_seg2", {a1, b1, c1, d1, e1, f1, g1, h1}, {7'b0110001, 1'b1});
    run(154, 8'hC0, y4, x4);
    chk("chg_cur_hi", x1 + y1 + y4, 64);
    run(256, 8'hC0, x1, x4);
    chk("chg_next_hi", x1, 192);

    // Sweep the upper nibble with lower nibble 8.
    for (int n = 0; n < 16; n++) begin
      ro = {n[3:0], 4'h8};
      step(1'b1, ro);
      step(1'b1, ro);
      chk("sweep_seg", {a1, b1, c1, d1, e1, f1, g1, h1}, {seg_tab[n], 1'b0});
    end

    // PRESCALE=4 with 50% duty.
    step(1'b0, 8'h80);
    step(1'b0, 8'h80);
    run(1024, 8'h80, x1, x4);
    chk("ps4_first_hi", x4, 0);
    run(1024, 8'h80, x1, x4);
    chk("ps4_hi", x4, 512);

    // One-clock reset pulse mid-period.
    run(1000, 8'h80, x1, x4);
    step(1'b0, 8'h80);
    chk("pulse_pwm", pwm1, 1'b0);
    chk("pulse_seg", {a1, b1, c1, d1, e1, f1, g1, h1}, 8'hFF);
    run(256, 8'h80, x1, x4);
    chk("pulse_dead_hi", x1, 0);
    run(256, 8'h80, x1, x4);
    chk("pulse_resume_hi", x1, 128);

    // Random operand changes with occasional reset pulses.
    ro = 8'($urandom);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 3) ro = 8'($urandom);
      step(($urandom_range(0, 599) != 0), ro);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
